// File: rtl/rv_thread_pkg.sv
// Shared types and one-hot/thread-id helpers for the barrel-pipeline thread scheduler.
// The optional idle-cycle counter in rv_thread_issue is enabled with RV_ISSUE_PERF_EN.
package rv_thread_pkg;

  localparam int NTHREADS_DEF = 7;
  localparam int TID_W_DEF    = $clog2(NTHREADS_DEF);
  localparam int MAX_THREADS  = 16;

  typedef logic [TID_W_DEF-1:0] tid_t;

  // OR-reduce encoder: correct only for one-hot or all-zero inputs.
  function automatic logic [3:0] onehot2tid(input logic [MAX_THREADS-1:0] oh);
    logic [3:0] t;
    t = '0;
    for (int i = 0; i < MAX_THREADS; i++) begin
      if (oh[i]) t = t | 4'(i);
    end
    return t;
  endfunction

  function automatic logic [MAX_THREADS-1:0] tid2onehot(input logic [3:0] tid);
    return 16'(1) << tid;
  endfunction

endpackage

// File: rtl/rv_thread_issue_if.sv
// Issue and retire channels between the thread scheduler and the pipeline.
// Issue: a transfer happens on a clock edge where issue_valid && issue_ready; the offer
// (issue_tid/issue_onehot) is held stable while valid && !ready. Retire is a one-cycle pulse.
interface rv_thread_issue_if #(
  parameter int NTHREADS = 7,
  parameter int TID_W    = $clog2(NTHREADS)
);
  logic                issue_valid;
  logic                issue_ready;
  logic [TID_W-1:0]    issue_tid;
  logic [NTHREADS-1:0] issue_onehot;
  logic                retire_valid;
  logic [TID_W-1:0]    retire_tid;

  modport master (
    output issue_valid, issue_tid, issue_onehot,
    input  issue_ready, retire_valid, retire_tid
  );

  modport slave (
    input  issue_valid, issue_tid, issue_onehot,
    output issue_ready, retire_valid, retire_tid
  );
endinterface

// File: rtl/rv_rr_pick.sv
// Combinational rotating-priority picker: lowest set bit of mask at or above the one-hot ptr,
// wrapping to the lowest set bit overall.
module rv_rr_pick
  import rv_thread_pkg::*;
#(
  parameter int N     = 7,
  parameter int TID_W = $clog2(N)
) (
  input  logic [N-1:0]     mask,
  input  logic [N-1:0]     ptr,
  output logic             any,
  output logic [N-1:0]     onehot,
  output logic [TID_W-1:0] tid
);

  logic [N-1:0] at_or_above;
  logic [N-1:0] masked_hi;
  logic [N-1:0] sel;

  always_comb begin
    at_or_above = ~(ptr - N'(1));
    masked_hi   = mask & at_or_above;
    sel         = (|masked_hi) ? masked_hi : mask;
    // Isolate lowest set bit with two's-complement trick.
    onehot      = sel & (~sel + N'(1));
    any         = |mask;
    tid         = TID_W'(onehot2tid(MAX_THREADS'(onehot)));
  end

endmodule

// File: rtl/rv_thread_issue.sv
// Round-robin hardware-thread issue scheduler with at most one in-flight instruction per thread.
// Optional feature macro: RV_ISSUE_PERF_EN enables the 32-bit idle-cycle counter.
module rv_thread_issue
  import rv_thread_pkg::*;
#(
  parameter int NTHREADS = NTHREADS_DEF,
  parameter int TID_W    = $clog2(NTHREADS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NTHREADS-1:0] thr_en,
  rv_thread_issue_if.master   bus,
  output logic [NTHREADS-1:0] busy,
  output logic                err,
  output logic [31:0]         perf_idle_cnt
);

  logic                issue_valid_q;
  logic [TID_W-1:0]    issue_tid_q;
  logic [NTHREADS-1:0] issue_onehot_q;
  logic [NTHREADS-1:0] busy_q;
  logic [NTHREADS-1:0] ptr_q;
  logic                err_q;

  logic [NTHREADS-1:0] elig;
  logic                pick_any;
  logic [NTHREADS-1:0] pick_onehot;
  logic [TID_W-1:0]    pick_tid;

  logic                stage_free;
  logic                load;
  logic                retire_in_range;
  logic [NTHREADS-1:0] retire_oh;
  logic                retire_ok;
  logic                retire_bad;
  logic [NTHREADS-1:0] busy_nxt;

  // Registered busy only: a thread retired this cycle is not eligible until next cycle.
  assign elig = thr_en & ~busy_q;

  rv_rr_pick #(.N(NTHREADS), .TID_W(TID_W)) u_pick (
    .mask   (elig),
    .ptr    (ptr_q),
    .any    (pick_any),
    .onehot (pick_onehot),
    .tid    (pick_tid)
  );

  always_comb begin
    stage_free      = !issue_valid_q || bus.issue_ready;
    load            = stage_free && pick_any;
    retire_in_range = int'(bus.retire_tid) < NTHREADS;
    retire_oh       = NTHREADS'(tid2onehot(4'(bus.retire_tid)));
    retire_ok       = bus.retire_valid && retire_in_range && (|(retire_oh & busy_q));
    retire_bad      = bus.retire_valid && !retire_ok;
    busy_nxt        = busy_q;
    if (retire_ok) busy_nxt = busy_nxt & ~retire_oh;
    if (load)      busy_nxt = busy_nxt | pick_onehot;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      issue_valid_q  <= 1'b0;
      issue_tid_q    <= '0;
      issue_onehot_q <= '0;
      busy_q         <= '0;
      ptr_q          <= NTHREADS'(1);
      err_q          <= 1'b0;
    end else begin
      busy_q <= busy_nxt;
      if (retire_bad) err_q <= 1'b1;
      if (load) begin
        issue_valid_q  <= 1'b1;
        issue_tid_q    <= pick_tid;
        issue_onehot_q <= pick_onehot;
        ptr_q          <= {pick_onehot[NTHREADS-2:0], pick_onehot[NTHREADS-1]};
      end else if (stage_free) begin
        // Nothing eligible: drop the offer but keep the last tid visible.
        issue_valid_q  <= 1'b0;
        issue_onehot_q <= '0;
      end
    end
  end

  assign bus.issue_valid  = issue_valid_q;
  assign bus.issue_tid    = issue_tid_q;
  assign bus.issue_onehot = issue_onehot_q;
  assign busy             = busy_q;
  assign err              = err_q;

`ifdef RV_ISSUE_PERF_EN
  logic [31:0] idle_cnt_q;

  always_ff @(posedge clk) begin
    if (rst)                 idle_cnt_q <= '0;
    else if (!issue_valid_q) idle_cnt_q <= idle_cnt_q + 32'd1;
  end

  assign perf_idle_cnt = idle_cnt_q;
`else
  assign perf_idle_cnt = '0;
`endif

endmodule

// File: tb/tb_rv_thread_issue.sv
// Directed and randomized bench for rv_thread_issue against a queue/array reference model.
module tb_rv_thread_issue;

  localparam int NT = 7;
  localparam int TW = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [NT-1:0] thr_en = '0;
  logic [NT-1:0] busy;
  logic          err;
  logic [31:0]   perf_idle_cnt;

  rv_thread_issue_if #(.NTHREADS(NT), .TID_W(TW)) bus ();

  rv_thread_issue #(.NTHREADS(NT), .TID_W(TW)) dut (
    .clk           (clk),
    .rst           (rst),
    .thr_en        (thr_en),
    .bus           (bus),
    .busy          (busy),
    .err           (err),
    .perf_idle_cnt (perf_idle_cnt)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model state
  bit          m_busy[NT];
  int          m_ptr;
  bit          m_valid;
  int          m_tid;
  bit          m_err;
  logic [31:0] m_cnt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model_busy();
    logic [31:0] v;
    v = '0;
    for (int i = 0; i < NT; i++) if (m_busy[i]) v = v | (32'd1 << i);
    return v;
  endfunction

  task automatic check_all();
    chk("issue_valid", 32'(bus.issue_valid), 32'(m_valid));
    chk("issue_tid", 32'(bus.issue_tid), 32'(m_tid));
    chk("issue_onehot", 32'(bus.issue_onehot), m_valid ? (32'd1 << m_tid) : 32'd0);
    chk("busy", 32'(busy), model_busy());
    chk("err", 32'(err), 32'(m_err));
`ifdef RV_ISSUE_PERF_EN
    chk("perf_idle_cnt", perf_idle_cnt, m_cnt);
`else
    chk("perf_idle_cnt", perf_idle_cnt, 32'd0);
`endif
  endtask

  // Advance one clock: model computes next state from current inputs, then DUT is compared.
  task automatic tick();
    int  pick;
    int  idx;
    bit  was_valid;
    int  rt;
    was_valid = m_valid;
    if (rst) begin
      foreach (m_busy[i]) m_busy[i] = 0;
      m_ptr = 0; m_valid = 0; m_tid = 0; m_err = 0; m_cnt = '0;
    end else begin
      pick = -1;
      for (int k = 0; k < NT; k++) begin
        idx = (m_ptr + k) % NT;
        if (pick < 0 && thr_en[idx] && !m_busy[idx]) pick = idx;
      end
      if (bus.retire_valid) begin
        rt = int'(bus.retire_tid);
        if (rt >= NT) m_err = 1;
        else if (!m_busy[rt]) m_err = 1;
        else m_busy[rt] = 0;
      end
      if (!m_valid || bus.issue_ready) begin
        if (pick >= 0) begin
          m_valid = 1; m_tid = pick; m_busy[pick] = 1; m_ptr = (pick + 1) % NT;
        end else begin
          m_valid = 0;
        end
      end
      if (!was_valid) m_cnt = m_cnt + 32'd1;
    end
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.retire_valid = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    int seq[6];
    bit hs;
    int hs_tid;
    int cand[$];
    int r;

    bus.issue_ready  = 1'b0;
    bus.retire_valid = 1'b0;
    bus.retire_tid   = '0;

    // Reset state
    tick();
    tick();
    chk("rst_valid", 32'(bus.issue_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    rst = 1'b0;

    // Full sweep
    thr_en = 7'h7F;
    bus.issue_ready = 1'b1;
    for (int c = 0; c < NT; c++) begin
      tick();
      chk("sweep_tid", 32'(bus.issue_tid), 32'(c));
    end
    tick();
    chk("sweep_idle", 32'(bus.issue_valid), 32'd0);
    chk("sweep_busy", 32'(busy), 32'h7F);

    // Skip disabled threads, retire one cycle after each handshake
    do_reset();
    thr_en = 7'b0100101;
    seq = '{0, 2, 5, 0, 2, 5};
    for (int c = 0; c < 6; c++) begin
      hs = m_valid && bus.issue_ready;
      hs_tid = m_tid;
      tick();
      chk("skip_tid", 32'(bus.issue_tid), 32'(seq[c]));
      bus.retire_valid = hs;
      bus.retire_tid = TW'(hs_tid);
    end
    bus.retire_valid = 1'b0;

    // Backpressure with tid 3 staged
    do_reset();
    thr_en = 7'h7F;
    bus.issue_ready = 1'b1;
    repeat (4) tick();
    chk("bp_staged", 32'(bus.issue_tid), 32'd3);
    bus.issue_ready = 1'b0;
    repeat (5) begin
      tick();
      chk("bp_hold", 32'(bus.issue_tid), 32'd3);
    end
    bus.issue_ready = 1'b1;
    tick();
    chk("bp_next", 32'(bus.issue_tid), 32'd4);

    // Retire latency: only thread 2
    do_reset();
    thr_en = 7'b0000100;
    tick();
    tick();
    chk("lat_drained", 32'(bus.issue_valid), 32'd0);
    bus.retire_valid = 1'b1;
    bus.retire_tid = 3'd2;
    tick();
    bus.retire_valid = 1'b0;
    chk("lat_busy_clear", 32'(busy[2]), 32'd0);
    chk("lat_not_yet", 32'(bus.issue_valid), 32'd0);
    tick();
    chk("lat_reissue_v", 32'(bus.issue_valid), 32'd1);
    chk("lat_reissue_tid", 32'(bus.issue_tid), 32'd2);

    // Protocol errors
    do_reset();
    thr_en = '0;
    bus.retire_valid = 1'b1;
    bus.retire_tid = 3'd4;
    tick();
    bus.retire_valid = 1'b0;
    chk("err_notbusy", 32'(err), 32'd1);
    chk("err_busy_same", 32'(busy), 32'd0);
    repeat (2) tick();
    chk("err_sticky", 32'(err), 32'd1);
    do_reset();
    bus.retire_valid = 1'b1;
    bus.retire_tid = 3'd7;
    tick();
    bus.retire_valid = 1'b0;
    chk("err_range", 32'(err), 32'd1);

    // Reset mid-run
    do_reset();
    thr_en = 7'h1F;
    bus.issue_ready = 1'b1;
    repeat (5) tick();
    chk("mid_busy", 32'(busy), 32'h1F);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_valid", 32'(bus.issue_valid), 32'd0);
    chk("mid_onehot", 32'(bus.issue_onehot), 32'd0);
    chk("mid_busy0", 32'(busy), 32'd0);
    chk("mid_perf", perf_idle_cnt, 32'd0);
    thr_en = 7'h7F;
    tick();
    chk("mid_first_tid", 32'(bus.issue_tid), 32'd0);
    bus.retire_valid = 1'b1;
    bus.retire_tid = 3'd3;
    tick();
    bus.retire_valid = 1'b0;
    chk("mid_late_retire", 32'(err), 32'd1);

    // Randomized traffic
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      thr_en = NT'($urandom);
      bus.issue_ready = ($urandom_range(0, 3) != 0);
      cand.delete();
      for (int i = 0; i < NT; i++) if (m_busy[i]) cand.push_back(i);
      r = $urandom_range(0, 99);
      bus.retire_valid = 1'b0;
      if (r < 2) begin
        bus.retire_valid = 1'b1;
        bus.retire_tid = TW'($urandom_range(0, 7));
      end else if (r < 55 && cand.size() > 0) begin
        bus.retire_valid = 1'b1;
        bus.retire_tid = TW'(cand[$urandom_range(0, cand.size() - 1)]);
      end
      rst = ($urandom_range(0, 199) == 0);
      tick();
    end
    rst = 1'b0;
    bus.retire_valid = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/rv_thread_issue.md
Name: rv_thread_issue

Overview:
- Round-robin hardware-thread issue scheduler for the barrel pipeline; the consumer-side counterpart of the rotating slot-enable ring.
- Each cycle it offers at most one thread to the fetch/issue stage with a valid/ready handshake. It skips threads that are disabled or still have an instruction in flight.
- Threads are released by a retire report from writeback. The invariant is at most one in-flight instruction per thread.

Parameters:
- NTHREADS, 7, number of hardware threads (2..16)
- TID_W, $clog2(NTHREADS), thread-id width

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- thr_en  in  NTHREADS  per-thread runnable mask (level)
- issue_valid  out  1  issue register holds a selected thread
- issue_ready  in  1  pipeline accepts the issue this cycle
- issue_tid  out  TID_W  selected thread id
- issue_onehot  out  NTHREADS  one-hot of issue_tid; all zero when not valid
- retire_valid  in  1  writeback retires an instruction
- retire_tid  in  TID_W  thread being retired
- busy  out  NTHREADS  in-flight mask
- err  out  1  sticky protocol error
- perf_idle_cnt  out  32  idle-cycle count; tied to 0 unless the feature macro is defined

Behaviour:
- Clock and reset: single clock, reset synchronous active-high (rst sampled on posedge clk).
- Reset values:
  - issue_valid=0, issue_tid=0, issue_onehot=0, busy=0, err=0, perf_idle_cnt=0.
  - Round-robin pointer ptr=one-hot bit 0, so thread 0 has first priority.
- Eligibility: elig = thr_en & ~busy. Uses registered busy only; no same-cycle retire bypass.
- Selection: the first set bit of elig, searching from ptr upward and wrapping at NTHREADS-1 -> 0.
- Issue register load:
  - Loads when (!issue_valid || issue_ready) && |elig.
  - On load: issue_valid<=1, issue_tid/onehot<=pick, busy[pick]<=1, ptr<=rotate-left(onehot(pick)).
- Issue register clear: if (!issue_valid || issue_ready) && elig==0, then issue_valid<=0 and issue_onehot<=0. issue_tid holds its last value.
- Backpressure: while issue_valid && !issue_ready, issue_tid and issue_onehot are held stable and ptr does not move.
- Throughput: one issue per cycle under continuous ready.
- Latency: thread eligible at cycle t -> issue_valid at t+1.
- Retire:
  - retire_valid with busy[retire_tid]=1 clears busy[retire_tid] at the next edge.
  - The thread is eligible again the cycle after the clear; earliest re-issue is 2 cycles after retire_valid.
- Retire and load in the same cycle always target different threads, because a busy thread is never picked. Both updates apply.
- Errors: err is set and held until rst on either of:
  - retire_valid with busy[retire_tid]=0, or
  - retire_tid >= NTHREADS.
  - The offending retire otherwise has no effect.
- thr_en dropping:
  - For a busy thread: busy stays set until retire.
  - For the staged thread: the issue is not withdrawn.
- Pointer wrap: selecting NTHREADS-1 sets ptr to bit 0.
- rst mid-operation: all state returns to reset values. In-flight threads are forgotten, and late retires after reset set err.

Optional Feature:
- Macro: RV_ISSUE_PERF_EN.
- Defined: 32-bit perf_idle_cnt increments every cycle with issue_valid=0, wraps at 2^32-1 -> 0, and is cleared by rst.
- Undefined: no counter register; perf_idle_cnt is driven constant 0.

Decomposition:
- Package rv_thread_pkg holds:
  - NTHREADS_DEF=7 and TID_W_DEF
  - typedef tid_t, logic [TID_W_DEF-1:0]
  - functions onehot2tid() and tid2onehot()
- Sub-module rv_rr_pick: combinational rotating-priority picker.
  - Inputs: mask, ptr.
  - Outputs: any, onehot, tid.
  - Reused by future arbiters.

Test Plan:
- Full sweep: thr_en=7'h7F, issue_ready=1, no retires -> issue_tid 0,1,2,3,4,5,6 on cycles 1..7; cycle 8 issue_valid=0; busy=7'h7F.
- Skip: thr_en=7'b0100101, retire every issue 1 cycle after handshake -> order 0,2,5,0,2,5...; issue_onehot matches each tid.
- Backpressure: issue_ready=0 for 5 cycles while tid 3 is staged -> issue_tid=3 stable, ptr unchanged; then ready=1 -> next issue is tid 4.
- Retire latency: only thread 2 enabled, retire_valid/tid=2 at cycle t -> busy[2]=0 at t+1, issue_valid with tid 2 at t+2.
- Error: retire_tid=4 while busy[4]=0 -> err=1 next cycle and stays 1; busy unchanged. Also retire_tid=7 with NTHREADS=7 -> err=1.
- Reset mid-run: rst for 1 cycle while busy=7'h1F and issue_valid=1 -> all outputs 0 next cycle; first issue after rst deasserts is tid 0. With RV_ISSUE_PERF_EN, perf_idle_cnt=0 after rst and counts idle cycles thereafter.
